// File: rtl/fadd32_seq_if.sv
// Operand/result handshake bundle for the fadd32_seq float adder.
// The slave side is the adder itself; the master side is the issuing ALU.
interface fadd32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        busy;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/fadd32_seq.sv
// Multi-cycle binary32 adder: decompose, align, add/subtract, normalize, then
// hold the truncated result until the consumer takes it.
module fadd32_seq (
  input  logic         clk,
  input  logic         rst_n,
  fadd32_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [9:0]  exp_q, exp_d;
  logic [31:0] frac_l_q, frac_l_d;
  logic [31:0] frac_s_q, frac_s_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  exp_a, exp_b, exp_l, exp_s, diff;
  logic [22:0] man_a, man_b, man_l, man_s;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_is_l, sign_l;
  logic [32:0] sum33;
  logic [31:0] diff32;

  assign exp_a  = bus.op1[30:23];
  assign exp_b  = bus.op2[30:23];
  assign man_a  = bus.op1[22:0];
  assign man_b  = bus.op2[22:0];
  assign a_zero = (exp_a == 8'd0);
  assign b_zero = (exp_b == 8'd0);
  assign a_inf  = (exp_a == 8'hFF) && (man_a == 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (man_b == 23'd0);
  assign a_nan  = (exp_a == 8'hFF) && (man_a != 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (man_b != 23'd0);

  // Ties on the full magnitude keep op1 as the larger operand.
  assign a_is_l = {exp_a, man_a} >= {exp_b, man_b};
  assign exp_l  = a_is_l ? exp_a : exp_b;
  assign exp_s  = a_is_l ? exp_b : exp_a;
  assign man_l  = a_is_l ? man_a : man_b;
  assign man_s  = a_is_l ? man_b : man_a;
  assign sign_l = a_is_l ? bus.op1[31] : bus.op2[31];
  assign diff   = exp_l - exp_s;

  assign sum33  = {1'b0, frac_l_q} + {1'b0, frac_s_q};
  assign diff32 = frac_l_q - frac_s_q;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    exp_d       = exp_q;
    frac_l_d    = frac_l_q;
    frac_s_d    = frac_s_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Specials park in DONE with out_valid still low; DONE raises it next cycle.
          state_d = DONE;
          if (a_nan || b_nan) begin
            res_d = 32'h7FC00000;
          end else if (a_inf && b_inf && (bus.op1[31] != bus.op2[31])) begin
            res_d = 32'h7FC00000;
          end else if (a_inf) begin
            res_d = bus.op1;
          end else if (b_inf) begin
            res_d = bus.op2;
          end else if (a_zero && b_zero) begin
            res_d = {bus.op1[31] & bus.op2[31], 31'd0};
          end else if (a_zero) begin
            res_d = bus.op2;
          end else if (b_zero) begin
            res_d = bus.op1;
          end else begin
            state_d  = ALIGN;
            sign_d   = sign_l;
            sub_d    = bus.op1[31] ^ bus.op2[31];
            exp_d    = {2'b00, exp_l};
            frac_l_d = {1'b1, man_l, 8'd0};
            if (diff > 8'd26) begin
              frac_s_d = 32'd0;
              cnt_d    = 5'd0;
            end else begin
              frac_s_d = {1'b1, man_s, 8'd0};
              cnt_d    = diff[4:0];
            end
          end
        end
      end

      ALIGN: begin
        if (cnt_q != 5'd0) begin
          frac_s_d = {1'b0, frac_s_q[31:2], frac_s_q[1] | frac_s_q[0]};
          cnt_d    = cnt_q - 5'd1;
        end else begin
          state_d = ADD;
        end
      end

      ADD: begin
        if (!sub_q) begin
          if (sum33[32]) begin
            frac_l_d = {sum33[32:2], sum33[1] | sum33[0]};
            exp_d    = exp_q + 10'd1;
          end else begin
            frac_l_d = sum33[31:0];
          end
        end else begin
          frac_l_d = diff32;
        end
        state_d = NORM;
      end

      NORM: begin
        if (frac_l_q == 32'd0) begin
          res_d       = 32'h00000000;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else if (exp_q >= 10'd255) begin
          res_d       = {sign_q, 8'hFF, 23'd0};
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else if (frac_l_q[31]) begin
          res_d       = {sign_q, exp_q[7:0], frac_l_q[30:8]};
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          frac_l_d = {frac_l_q[30:0], 1'b0};
          exp_d    = exp_q - 10'd1;
          if (exp_q == 10'd1) begin
            res_d       = {sign_q, 31'd0};
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end

      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= 10'd0;
      frac_l_q    <= 32'd0;
      frac_s_q    <= 32'd0;
      cnt_q       <= 5'd0;
      res_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      exp_q       <= exp_d;
      frac_l_q    <= frac_l_d;
      frac_s_q    <= frac_s_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
